// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the ROM read-channel arbiter family.
// Holds default widths, the arbiter FSM state type and the round-robin wrap helper.
package rom_arb_pkg;

  localparam int ADDR_W_DEF = 25;
  localparam int DATA_W_DEF = 64;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Successor of ptr in a ring of n slots.
  function automatic int next_idx(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of pending at or after ptr,
// wrapping around. Shared by the shared-port arbiters.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic found;
  int   c;

  always_comb begin
    valid = |pending;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!found && pending[c]) begin
        found = 1'b1;
        idx   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/rom_channel_arbiter.sv
// Round-robin share of one toggle-handshake ROM read channel among NUM_REQ
// clients; each client keeps its own held copy of the last returned word.
module rom_channel_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  cli_addr,
  input  logic [NUM_REQ-1:0]              cli_req,
  output logic [NUM_REQ-1:0]              cli_ack,
  output logic [NUM_REQ-1:0][DATA_W-1:0]  cli_dout,
  output logic [ADDR_W-1:0]               rom_addr,
  output logic                            rom_req,
  input  logic                            rom_ack,
  input  logic [DATA_W-1:0]               rom_dout,
  output logic                            busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t              state;
  logic [IW-1:0]       grant;
  logic [IW-1:0]       rr_ptr;
  logic                req_snap;
  logic [NUM_REQ-1:0]  pending;
  logic                pick_vld;
  logic [IW-1:0]       pick_idx;
  logic                done;

  assign pending = cli_req ^ cli_ack;
  assign done    = (state == WAIT) && (rom_ack == rom_req);

  rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
    .pending (pending),
    .ptr     (rr_ptr),
    .valid   (pick_vld),
    .idx     (pick_idx)
  );

  // Ack takes the request level seen at grant, so a toggle that arrived
  // during WAIT leaves the client pending and it is served again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      req_snap <= 1'b0;
      rom_addr <= '0;
      rom_req  <= 1'b0;
      busy     <= 1'b0;
      cli_ack  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant    <= pick_idx;
            rom_addr <= cli_addr[pick_idx];
            req_snap <= cli_req[pick_idx];
            rom_req  <= ~rom_req;
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (rom_ack == rom_req) begin
            cli_ack[grant] <= req_snap;
            rr_ptr         <= IW'(next_idx(int'(grant), NUM_REQ));
            busy           <= 1'b0;
            state          <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cli_dout <= '0;
    end else if (done) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (grant == IW'(i)) cli_dout[i] <= rom_dout;
    end
  end

endmodule

// File: tb/tb_rom_channel_arbiter.sv
// Bench for rom_channel_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-level round-robin model with a bench-owned ROM responder.
module tb_rom_channel_arbiter;

  localparam int NR = 2;
  localparam int AW = 25;
  localparam int DW = 64;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NR-1:0][AW-1:0]   cli_addr;
  logic [NR-1:0]           cli_req;
  logic [NR-1:0]           cli_ack;
  logic [NR-1:0][DW-1:0]   cli_dout;
  logic [AW-1:0]           rom_addr;
  logic                    rom_req;
  logic                    rom_ack;
  logic [DW-1:0]           rom_dout;
  logic                    busy;

  always #5 clk = ~clk;

  rom_channel_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .cli_addr (cli_addr),
    .cli_req  (cli_req),
    .cli_ack  (cli_ack),
    .cli_dout (cli_dout),
    .rom_addr (rom_addr),
    .rom_req  (rom_req),
    .rom_ack  (rom_ack),
    .rom_dout (rom_dout),
    .busy     (busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Model state: which clients the bench has asked and not yet seen served.
  logic [NR-1:0]   pend;
  int              rr_m;
  bit              outst;
  int              cur;
  bit              ack_due;
  int              dly;
  bit              hold;
  int              fix_dly;
  bit              fix_data_en;
  logic [DW-1:0]   fix_data;
  logic [DW-1:0]   cur_data;
  logic [DW-1:0]   exp_dout [NR];
  logic [AW-1:0]   addr_of  [NR];
  logic            req_seen;
  logic [NR-1:0]   ack_seen;
  int              glog[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int pick_m();
    for (int k = 0; k < NR; k++)
      if (pend[(rr_m + k) % NR]) return (rr_m + k) % NR;
    return -1;
  endfunction

  task automatic model_reset();
    pend = '0; rr_m = 0; outst = 0; cur = 0; ack_due = 0; dly = 0;
    req_seen = 1'b0; ack_seen = '0;
    for (int i = 0; i < NR; i++) begin exp_dout[i] = '0; addr_of[i] = '0; end
    cli_req = '0; cli_addr = '0; rom_ack = 1'b0; rom_dout = '0;
  endtask

  task automatic request(input int c, input logic [AW-1:0] a);
    addr_of[c]  = a;
    cli_addr[c] = a;
    cli_req[c]  = ~cli_req[c];
    pend[c]     = 1'b1;
  endtask

  // One clock: observe completions and issues, then act as the ROM.
  task automatic step();
    logic [NR-1:0] chg;
    logic [NR-1:0] exp_chg;
    bit            tog;
    bit            exp_iss;
    int            c;
    int            dc;
    exp_iss = !outst && (pend != '0);
    @(negedge clk);
    chg = cli_ack ^ ack_seen;
    exp_chg = '0;
    if (ack_due) exp_chg[cur] = 1'b1;
    if (ack_due || chg != '0) begin
      chk("ack_lat", chg, exp_chg);
      ack_seen = cli_ack;
      if (ack_due) begin
        exp_dout[cur] = cur_data;
        pend[cur] = 1'b0;
        outst = 0;
        ack_due = 0;
        rr_m = (cur + 1) % NR;
        for (int j = 0; j < NR; j++) chk("dout", cli_dout[j], exp_dout[j]);
      end
    end
    chk("ack_val", cli_ack, cli_req ^ pend);
    tog = (rom_req != req_seen);
    chk("issue", tog, exp_iss);
    if (tog) begin
      req_seen = rom_req;
      c = pick_m();
      dc = -1;
      for (int j = 0; j < NR; j++) if (pend[j] && addr_of[j] == rom_addr) dc = j;
      glog.push_back(dc);
      chk("grant", dc, c);
      if (c >= 0) cur = c;
      outst = 1;
      dly = (fix_dly >= 0) ? fix_dly : $urandom_range(0, 5);
      cur_data = fix_data_en ? fix_data : {$urandom, $urandom};
    end
    chk("busy", busy, outst);
    if (outst && !ack_due && !hold) begin
      if (dly == 0) begin
        rom_dout = cur_data;
        rom_ack  = rom_req;
        ack_due  = 1;
      end else dly--;
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 2000 && (outst || pend != '0); k++) step();
    if (outst || pend != '0) chk("timeout", {outst, pend}, 0);
  endtask

  initial begin
    logic [AW-1:0] sa;
    logic          sreq;
    reset = 1'b0;
    hold = 0; fix_dly = -1; fix_data_en = 0; fix_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ack", cli_ack, 0);
    chk("rst_rom", {rom_req, busy, rom_addr}, 0);
    for (int j = 0; j < NR; j++) chk("rst_dout", cli_dout[j], 0);
    reset = 1'b1;

    // Single request, ROM answers after 5 cycles.
    step();
    fix_dly = 5; fix_data_en = 1; fix_data = 64'h0123456789ABCDEF;
    request(0, 25'h0400008);
    step();
    chk("t1_req", rom_req, 1);
    chk("t1_addr", rom_addr, 25'h0400008);
    wait_idle();
    chk("t1_ack", cli_ack[0], 1);
    chk("t1_dout", cli_dout[0], 64'h0123456789ABCDEF);

    // Data isolation: client 1 gets all ones, client 0 keeps its word.
    fix_data = '1;
    request(1, 25'h0000101);
    wait_idle();
    chk("iso0", cli_dout[0], 64'h0123456789ABCDEF);
    chk("iso1", cli_dout[1], 64'hFFFFFFFFFFFFFFFF);

    // Contention with rr pointer back at 0.
    fix_dly = -1; fix_data_en = 0;
    glog.delete();
    request(0, 25'h0001230);
    request(1, 25'h0004561);
    wait_idle();
    chk("cont_n", glog.size(), 2);
    if (glog.size() >= 2) begin
      chk("cont_0", glog[0], 0);
      chk("cont_1", glog[1], 1);
    end

    // Fairness: both clients re-request as soon as they are served.
    glog.delete();
    request(0, 25'h0010000);
    request(1, 25'h0020001);
    for (int k = 0; k < 500 && glog.size() < 8; k++) begin
      step();
      for (int c = 0; c < NR; c++)
        if (!pend[c] && glog.size() < 8) request(c, {22'($urandom), 3'(c)});
    end
    wait_idle();
    chk("fair_n", glog.size() >= 8, 1);
    for (int k = 0; k < glog.size() && k < 8; k++) chk("fair", glog[k], k % 2);

    // Stall: the ROM withholds its ack.
    hold = 1;
    request(0, 25'h1555550);
    step();
    sa = rom_addr; sreq = rom_req;
    repeat (1000) step();
    chk("stall_busy", busy, 1);
    chk("stall_addr", rom_addr, 25'h1555550);
    chk("stall_hold", {rom_addr, rom_req}, {sa, sreq});
    hold = 0;
    wait_idle();

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      step();
      for (int c = 0; c < NR; c++)
        if (!pend[c] && $urandom_range(0, 2) == 0) request(c, {22'($urandom), 3'(c)});
    end
    wait_idle();

    // Reset in the middle of WAIT.
    hold = 1;
    request(1, 25'h0777771);
    step();
    step();
    chk("mid_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_ack", cli_ack, 0);
    chk("mid_rst_rom", {rom_req, busy, rom_addr}, 0);
    for (int j = 0; j < NR; j++) chk("mid_rst_dout", cli_dout[j], 0);
    hold = 0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("post_busy", busy, 0);
    request(1, 25'h0333331);
    step();
    chk("post_req", rom_req, 1);
    chk("post_addr", rom_addr, 25'h0333331);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rom_channel_arbiter.md
Name: rom_channel_arbiter

Overview:
- Shares one 64-bit SDRAM ROM read channel among NUM_REQ clients. Clients include the sample ROM fetcher and other ROM readers.
- Client side and downstream side both use the toggle handshake: a request is pending while req != ack.
- Arbitration is round-robin. Each client gets its own held data register, so returned words stay stable until that client's next request.
- Sits between the per-function ROM fetchers and the SDRAM controller port.

Parameters:
- NUM_REQ, 2, number of client ports (2..8).
- ADDR_W, 25, byte address width.
- DATA_W, 64, word width.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low (0 = reset asserted).
- cli_addr  input  NUM_REQ*ADDR_W  per-client byte address; slice i = client i.
- cli_req  input  NUM_REQ  per-client request toggle.
- cli_ack  output  NUM_REQ  per-client acknowledge toggle.
- cli_dout  output  NUM_REQ*DATA_W  per-client returned word, held.
- rom_addr  output  ADDR_W  downstream address.
- rom_req  output  1  downstream request toggle.
- rom_ack  input  1  downstream acknowledge toggle.
- rom_dout  input  DATA_W  downstream data, valid when rom_ack == rom_req.
- busy  output  1  high when the FSM is not in IDLE.

Behaviour:
- Reset values: cli_ack = 0, cli_dout = 0, rom_addr = 0, rom_req = 0, busy = 0, state = IDLE, rr pointer = 0. Reset is async assert, sync release.
- pending[i] = cli_req[i] ^ cli_ack[i]. It is evaluated combinationally each cycle.
- IDLE:
  - If any bit of pending is set, pick the first pending index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Register grant = idx, rom_addr = cli_addr[idx], and req_snap = cli_req[idx].
  - Toggle rom_req and go to WAIT. All of this happens in the same edge (one-cycle pick-to-issue).
- WAIT:
  - When rom_ack == rom_req, capture cli_dout[grant] <= rom_dout and set cli_ack[grant] <= req_snap.
  - Set rr_ptr <= grant+1 (wrap to 0 at NUM_REQ), then go to IDLE.
- Latency:
  - The client's toggle is seen at edge N; rom_req toggles at edge N.
  - Completion: cli_ack toggles one edge after the edge where rom_ack matches.
  - Minimum back-to-back gap is one IDLE cycle between downstream requests.
- Only one downstream request is ever outstanding. rom_addr stays stable throughout WAIT.
- cli_addr is sampled only at grant. Clients must hold the address and must not toggle again until their ack matches. Protocol violations are not detected.
- A second toggle while pending is not counted: cli_ack takes req_snap, so the client stays pending and is re-served.
- Simultaneous requests are all honoured in rr order. No client waits more than NUM_REQ-1 grants.
- A client re-requesting on the cycle its ack returns is treated as a new pending request. It does not win the very next grant if others are pending.
- cli_dout slices for non-granted clients never change.
- Reset mid-WAIT aborts the transaction and clears all state. The downstream controller shares the same reset, so its ack also returns to 0.
- No timeout: WAIT persists indefinitely if rom_ack never matches.

Decomposition:
- Package rom_arb_pkg holds:
  - ADDR_W/DATA_W defaults;
  - state enum {IDLE, WAIT};
  - helper function next_idx(ptr, n) for the modulo wrap.
- Sub-module rr_picker (combinational): inputs pending vector and rr_ptr; outputs valid and idx. Reusable by other shared-port arbiters.
- Top module holds the FSM, snapshot registers and data registers.

Test Plan:
- Single request: client0 addr 0x0400008 toggles cli_req[0] 0->1.
  - rom_req toggles the same edge with rom_addr = 0x0400008.
  - Drive rom_dout 0x0123456789ABCDEF and match rom_ack after 5 cycles.
  - Next edge: cli_ack[0] = 1 and cli_dout[0] = 0x0123456789ABCDEF.
- Contention: clients 0 and 1 toggle on the same cycle with rr_ptr = 0.
  - Client 0 is served first, then client 1 after one IDLE cycle.
  - The second rom_addr equals client 1's address.
- Fairness: client 0 re-requests immediately after every ack while client 1 stays pending. Grants alternate 0,1,0,1 over 8 transactions.
- Data isolation: serve client 1 with 0xFFFF...; client 0's slice keeps its previous 0x0123456789ABCDEF value.
- Reset mid-WAIT: pull reset low while in WAIT. Then:
  - all outputs go to 0 asynchronously;
  - after release, busy = 0;
  - a fresh request from client 1 is issued with rom_req 0->1.
- Stall: withhold rom_ack for 1000 cycles. busy stays 1, rom_addr is stable, and no second rom_req toggle occurs.
